// File: rtl/matrix_negate_seq.sv
// Sequential saturating negate of an NxN signed 8-bit matrix, one element per clock.
// Start latches the operand; done pulses once when the whole negated matrix is assembled.
module matrix_negate_seq #(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8*N*N-1:0] matrix_a,
  output logic [8*N*N-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned E  = N * N;
  localparam int unsigned IW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [8*E-1:0]  r_mat;
  logic [8*E-1:0]  r_result;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  logic [7:0]      w_elem;
  logic [7:0]      w_neg;
  logic            w_ovf;

  // Saturating negate of the element currently addressed by r_idx.
  assign w_elem = r_mat[{r_idx, 3'b000} +: 8];
  assign w_ovf  = (w_elem == 8'h80);
  assign w_neg  = w_ovf ? 8'h7F : (~w_elem + 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_mat    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mat    <= matrix_a;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[{r_idx, 3'b000} +: 8] <= w_neg;
          r_ovf <= r_ovf | w_ovf;
          if (r_idx == IW'(E - 1)) begin
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_matrix_negate_seq.sv
// Bench for matrix_negate_seq: cycle-level reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized start/reset phase.
module tb_matrix_negate_seq;

  localparam int N = 5;
  localparam int E = N * N;
  localparam int W = 8 * E;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] matrix_a = '0;
  logic [W-1:0] result;
  logic         busy, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  matrix_negate_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix_a(matrix_a),
    .result(result), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference negate: true arithmetic negation, clamped to the int8 range.
  function automatic logic [7:0] ref_neg(input logic [7:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 127) v = 127;
    return 8'(v);
  endfunction

  function automatic bit ref_ovf(input logic [7:0] x);
    return (-int'($signed(x))) > 127;
  endfunction

  // Reference model: an op is "a latched operand plus a count of elements processed so far".
  bit         m_busy;
  bit         m_done;
  bit         m_ovf;
  int         m_k;
  logic [7:0] m_op  [E];
  logic [7:0] m_res [E];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_k = 0;
      for (int i = 0; i < E; i++) begin m_op[i] = 8'h00; m_res[i] = 8'h00; end
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        for (int i = 0; i < E; i++) begin m_op[i] = matrix_a[8*i +: 8]; m_res[i] = 8'h00; end
        m_ovf = 0; m_k = 0; m_busy = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else begin
      m_res[m_k] = ref_neg(m_op[m_k]);
      m_ovf = m_ovf | ref_ovf(m_op[m_k]);
      m_k++;
      if (m_k == E) m_done = 1;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] exp_res;
      for (int i = 0; i < E; i++) exp_res[8*i +: 8] = m_res[i];
      n_tests++;
      if (busy !== m_busy || done !== m_done || overflow !== m_ovf || result !== exp_res) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b ovf=%b res=%h expected busy=%b done=%b ovf=%b res=%h",
                 $time, busy, done, overflow, result, m_busy, m_done, m_ovf, exp_res);
      end
    end
  end

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < E; i++) v[8*i +: 8] = b;
    return v;
  endfunction

  function automatic logic [W-1:0] neg_all(input logic [W-1:0] m);
    logic [W-1:0] v;
    for (int i = 0; i < E; i++) v[8*i +: 8] = ref_neg(m[8*i +: 8]);
    return v;
  endfunction

  // Issue one op; returns busy-cycle count, done-pulse count and result/overflow seen at done.
  task automatic run_op(input logic [W-1:0] m, input bit hold, input bit scramble,
                        output int nbusy, output int ndone,
                        output logic [W-1:0] res_at_done, output logic ovf_at_done);
    bit finished = 0;
    nbusy = 0; ndone = 0; res_at_done = '0; ovf_at_done = 1'b0;
    @(negedge clk);
    matrix_a = m; start = 1'b1;
    for (int c = 0; c < E + 10 && !finished; c++) begin
      @(negedge clk);
      start = hold;
      if (scramble) matrix_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (busy) nbusy++;
      if (done) begin ndone++; res_at_done = result; ovf_at_done = overflow; end
      if (!busy) finished = 1;
    end
    check("op_terminates", W'(finished), W'(1));
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int c = 0; c < 4 * E && !idle; c++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    check("wait_idle", W'(idle), W'(1));
  endtask

  initial begin
    int nb, nd;
    logic [W-1:0] r, m, exp_v;
    logic o;

    // Pin the reference negate itself against hand values.
    check("ref_neg_00", W'(ref_neg(8'h00)), W'(8'h00));
    check("ref_neg_7F", W'(ref_neg(8'h7F)), W'(8'h81));
    check("ref_neg_81", W'(ref_neg(8'h81)), W'(8'h7F));
    check("ref_neg_FF", W'(ref_neg(8'hFF)), W'(8'h01));
    check("ref_neg_80", W'(ref_neg(8'h80)), W'(8'h7F));
    check("ref_ovf_80", W'(ref_ovf(8'h80)), W'(1));
    check("ref_ovf_81", W'(ref_ovf(8'h81)), W'(0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_ovf", W'(overflow), W'(0));
    check("reset_result", result, '0);

    // All 5s: every slot becomes -5, no overflow, one done pulse, E+1 busy cycles.
    run_op(fill(8'h05), 0, 0, nb, nd, r, o);
    check("t1_result", r, fill(8'hFB));
    check("t1_ovf", W'(o), W'(0));
    check("t1_done_pulses", W'(nd), W'(1));
    check("t1_busy_cycles", W'(nb), W'(E + 1));

    // Extremes: -128 saturates, +127 maps to -127.
    m = '0; m[7:0] = 8'h80; m[W-1 -: 8] = 8'h7F;
    run_op(m, 0, 0, nb, nd, r, o);
    exp_v = '0; exp_v[7:0] = 8'h7F; exp_v[W-1 -: 8] = 8'h81;
    check("t2_result", r, exp_v);
    check("t2_ovf", W'(o), W'(1));

    // Start held high and operand scrambled during the op: result from the first latch only.
    m = fill(8'h11); m[15:8] = 8'hFF;
    run_op(m, 1, 1, nb, nd, r, o);
    exp_v = fill(8'hEF); exp_v[15:8] = 8'h01;
    check("t3_result", r, exp_v);
    check("t3_busy_cycles", W'(nb), W'(E + 1));
    @(negedge clk);
    check("t3_restart_in_idle", W'(busy), W'(1));
    start = 1'b0;
    wait_idle();

    // Reset in the middle of RUN at idx=10.
    @(negedge clk);
    matrix_a = fill(8'h80); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_busy", W'(busy), W'(0));
    check("t4_done", W'(done), W'(0));
    check("t4_result", result, '0);
    check("t4_ovf", W'(overflow), W'(0));
    rst = 1'b0;
    run_op(fill(8'h02), 0, 0, nb, nd, r, o);
    check("t4_after_result", r, fill(8'hFE));

    // Overflow from a previous op must not leak into the next.
    run_op(fill(8'h80), 0, 0, nb, nd, r, o);
    check("t5_op1_ovf", W'(o), W'(1));
    check("t5_op1_result", r, fill(8'h7F));
    run_op(fill(8'h7F), 0, 0, nb, nd, r, o);
    check("t5_op2_ovf", W'(o), W'(0));

    // Ramp -12..12 negates to 12..-12.
    for (int i = 0; i < E; i++) m[8*i +: 8] = 8'(i - 12);
    run_op(m, 0, 0, nb, nd, r, o);
    for (int i = 0; i < E; i++) exp_v[8*i +: 8] = 8'(12 - i);
    check("t6_result", r, exp_v);
    check("t6_busy_cycles", W'(nb), W'(E + 1));
    check("t6_result_held", result, exp_v);

    // Random starts, operands (with extra -128 density) and rare resets; model checks each cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < E; i++)
        matrix_a[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
